systolic_input_setup: RTL and testbench

Upstream feeder for the 2x2 systolic MMU and accumulator pair. It buffers a tile of activation vectors, each holding two 16-bit elements for row 0 and row 1. On a start command it streams the tile into the array's a_in1/a_in2 inputs with the diagonal one-cycle skew the array needs. valid_out drives the array/accumulator valid input.

---
 rtl/systolic_input_setup.sv | 211 +++++++++++++++++++++
 tb/tb_systolic_input_setup.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_input_setup.sv
// systolic_input_setup
// ---------------------------------------------------------------------------
// Upstream feeder for the 2x2 systolic MMU / accumulator pair. Buffers a tile
// of two-element activation vectors in a circular buffer, then on a start
// command streams the tile to the array with row 1 delayed by one cycle so
// the operands meet the diagonal wavefront inside the array.
//
// Ports:
//   clk        clock
//   reset      synchronous active-high reset
//   in_valid   write request for one vector {in_a1, in_a2}
//   in_ready   buffer can accept a vector this cycle (combinational)
//   in_a1      vector element for row 0
//   in_a2      vector element for row 1
//   start      begin streaming the buffered tile (sampled in IDLE only)
//   busy       high while streaming (STREAM and DRAIN)
//   done       one-cycle pulse after the last skewed element
//   count      buffer occupancy, 0..DEPTH
//   a_out1     row 0 operand to MMU a_in1
//   a_out2     row 1 operand to MMU a_in2 (skewed +1 cycle)
//   valid_out  valid to MMU / accumulator
//
// Build option:
//   INPUT_SETUP_REPLAY_EN  when defined, streaming is non-destructive: the
//                          read pointer rewinds at the end of a stream and
//                          count is untouched, so a later start replays the
//                          same tile. Only reset empties the buffer.
// ---------------------------------------------------------------------------
module systolic_input_setup #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a1,
    input  logic [DATA_W-1:0] in_a2,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic [DATA_W-1:0] a_out1,
    output logic [DATA_W-1:0] a_out2,
    output logic              valid_out
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    // Storage and pointer state
    logic [2*DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   start_ptr_q, start_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;

    // Control state: remain_q is the number of pops still owed in STREAM
    state_t              state_q, state_d;
    logic [ADDR_W:0]     remain_q, remain_d;
    logic [DATA_W-1:0]   prev_a2_q, prev_a2_d;

    // Registered outputs
    logic [DATA_W-1:0]   a_out1_q, a_out1_d;
    logic [DATA_W-1:0]   a_out2_q, a_out2_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                wr_fire;
    logic [DATA_W-1:0]   head_a1;
    logic [DATA_W-1:0]   head_a2;

    // start has priority over a write in the same IDLE cycle, so it gates in_ready.
    assign in_ready = (state_q == IDLE) && !start && (count_q < FULL_CNT);
    assign wr_fire  = in_valid && in_ready;

    assign head_a1 = mem_q[rd_ptr_q][2*DATA_W-1:DATA_W];
    assign head_a2 = mem_q[rd_ptr_q][DATA_W-1:0];

    // Buffer storage has no reset; pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= {in_a1, in_a2};
        end
    end

    // Next-state logic. Output registers are loaded with the values for the
    // state being entered, so a_out*/valid/busy/done line up with the state
    // that is current when they are visible. Each pop shows its a1 on row 0
    // immediately and parks its a2 in prev_a2 for row 0's successor cycle.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        start_ptr_d = start_ptr_q;
        count_d     = count_q;
        remain_d    = remain_q;
        prev_a2_d   = prev_a2_q;
        a_out1_d    = '0;
        a_out2_d    = '0;
        valid_d     = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && (count_q != '0)) begin
                    // First pop happens on the start edge; row 1 has nothing yet.
                    start_ptr_d = rd_ptr_q;
                    rd_ptr_d    = rd_ptr_q + PTR_ONE;
`ifndef INPUT_SETUP_REPLAY_EN
                    count_d     = count_q - CNT_ONE;
`endif
                    remain_d    = count_q - CNT_ONE;
                    prev_a2_d   = head_a2;
                    a_out1_d    = head_a1;
                    valid_d     = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = STREAM;
                end else if (wr_fire) begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    count_d  = count_q + CNT_ONE;
                end
            end

            STREAM: begin
                valid_d  = 1'b1;
                busy_d   = 1'b1;
                a_out2_d = prev_a2_q;
                if (remain_q != '0) begin
                    rd_ptr_d  = rd_ptr_q + PTR_ONE;
`ifndef INPUT_SETUP_REPLAY_EN
                    count_d   = count_q - CNT_ONE;
`endif
                    remain_d  = remain_q - CNT_ONE;
                    prev_a2_d = head_a2;
                    a_out1_d  = head_a1;
                end else begin
                    // Tail of the skew: row 0 is empty, row 1 gets the last a2.
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
`ifdef INPUT_SETUP_REPLAY_EN
                rd_ptr_d = start_ptr_q;
`endif
                done_d  = 1'b1;
                state_d = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; a reset mid-stream
    // drops straight back to IDLE with no done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            start_ptr_q <= '0;
            count_q     <= '0;
            remain_q    <= '0;
            prev_a2_q   <= '0;
            a_out1_q    <= '0;
            a_out2_q    <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            start_ptr_q <= start_ptr_d;
            count_q     <= count_d;
            remain_q    <= remain_d;
            prev_a2_q   <= prev_a2_d;
            a_out1_q    <= a_out1_d;
            a_out2_q    <= a_out2_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign a_out1    = a_out1_q;
    assign a_out2    = a_out2_q;
    assign valid_out = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign count     = count_q;

endmodule

// File: tb/tb_systolic_input_setup.sv
// tb_systolic_input_setup
// ---------------------------------------------------------------------------
// Directed bench for systolic_input_setup. A queue models buffer contents;
// each start turns the modelled tile into a queue of expected skewed beats
// that are popped and compared as the DUT streams.
// ---------------------------------------------------------------------------
module tb_systolic_input_setup;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    typedef struct {
        logic [DATA_W-1:0] a1;
        logic [DATA_W-1:0] a2;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_a1 = '0;
    logic [DATA_W-1:0] in_a2 = '0;
    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] a_out1;
    logic [DATA_W-1:0] a_out2;
    logic              valid_out;

    int compared = 0;
    int mismatched = 0;

    logic [2*DATA_W-1:0] mdl[$];
    beat_t               expQ[$];

    systolic_input_setup #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a1    (in_a1),
        .in_a2    (in_a2),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .a_out1   (a_out1),
        .a_out2   (a_out2),
        .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic resetDut();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        mdl.delete();
        expQ.delete();
    endtask

    // Offer one vector for a cycle; the model records it only if it should fit.
    task automatic applyStimulus(input logic [DATA_W-1:0] a1, input logic [DATA_W-1:0] a2);
        bit expReady;
        expReady = (mdl.size() < DEPTH);
        in_valid = 1'b1;
        in_a1    = a1;
        in_a2    = a2;
        #1;
        checkOutput("in_ready_write", in_ready, expReady);
        tick();
        in_valid = 1'b0;
        if (expReady) mdl.push_back({a1, a2});
        checkOutput("count_after_write", count, mdl.size());
    endtask

    // Start a stream of the modelled tile and compare every skewed beat,
    // the done pulse, and the post-stream occupancy.
    task automatic startAndCheck(input bit holdValid);
        int    n;
        beat_t b;
        n = mdl.size();
        for (int k = 0; k <= n; k++) begin
            b.a1 = (k < n) ? mdl[k][2*DATA_W-1:DATA_W] : '0;
            b.a2 = (k == 0) ? '0 : mdl[k-1][DATA_W-1:0];
            expQ.push_back(b);
        end
        start = 1'b1;
        if (holdValid) begin
            in_valid = 1'b1;
            in_a1    = 16'hDEAD;
            in_a2    = 16'hBEEF;
        end
        tick();
        start = 1'b0;
        for (int k = 0; k <= n; k++) begin
            b = expQ.pop_front();
            checkOutput("valid_out_stream", valid_out, 1);
            checkOutput("busy_stream", busy, 1);
            checkOutput("a_out1_stream", a_out1, b.a1);
            checkOutput("a_out2_stream", a_out2, b.a2);
            checkOutput("done_early", done, 0);
            if (holdValid) checkOutput("in_ready_stream", in_ready, 0);
            tick();
        end
        checkOutput("done_pulse", done, 1);
        checkOutput("valid_out_done", valid_out, 0);
        checkOutput("busy_done", busy, 0);
        checkOutput("a_out1_done", a_out1, 0);
        checkOutput("a_out2_done", a_out2, 0);
        in_valid = 1'b0;
`ifndef INPUT_SETUP_REPLAY_EN
        mdl.delete();
`endif
        checkOutput("count_after_done", count, mdl.size());
        tick();
        checkOutput("done_one_cycle", done, 0);
    endtask

    initial begin
        $display("[TB] systolic_input_setup bench starting");
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_valid", valid_out, 0);
        checkOutput("reset_a_out1", a_out1, 0);
        checkOutput("reset_a_out2", a_out2, 0);
        checkOutput("reset_count", count, 0);
        checkOutput("reset_in_ready", in_ready, 1);

        // Basic three-vector tile
        applyStimulus(16'd1, 16'd2);
        applyStimulus(16'd3, 16'd4);
        applyStimulus(16'd5, 16'd6);
        startAndCheck(1'b0);

        // Full buffer with wrapped pointers, dropped ninth write, then refill
        for (int k = 0; k < DEPTH; k++) applyStimulus(16'(k), 16'(100 + k));
        checkOutput("full_in_ready", in_ready, 0);
        applyStimulus(16'h00FF, 16'h00EE);
        startAndCheck(1'b0);
        for (int k = 0; k < DEPTH; k++) applyStimulus(16'(200 + k), 16'(300 + k));
        startAndCheck(1'b0);

        // start on empty buffer is ignored; start beats a simultaneous write
        resetDut();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checkOutput("empty_start_busy", busy, 0);
            checkOutput("empty_start_valid", valid_out, 0);
            checkOutput("empty_start_done", done, 0);
            tick();
        end
        start    = 1'b1;
        in_valid = 1'b1;
        in_a1    = 16'h1234;
        in_a2    = 16'h5678;
        #1;
        checkOutput("start_vs_write_ready", in_ready, 0);
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        checkOutput("start_vs_write_count", count, 0);
        checkOutput("start_vs_write_busy", busy, 0);

        // Writes held during a stream are refused; one write afterwards lands
        applyStimulus(16'hA001, 16'hB001);
        applyStimulus(16'hA002, 16'hB002);
        startAndCheck(1'b1);
        applyStimulus(16'hC003, 16'hD003);

        // Reset during a stream aborts with no done pulse, then recovers
        resetDut();
        for (int k = 0; k < 4; k++) applyStimulus(16'(10 + k), 16'(20 + k));
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("abort_a_out1_t1", a_out1, 10);
        checkOutput("abort_a_out2_t1", a_out2, 0);
        tick();
        checkOutput("abort_a_out1_t2", a_out1, 11);
        checkOutput("abort_a_out2_t2", a_out2, 20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mdl.delete();
        checkOutput("abort_valid", valid_out, 0);
        checkOutput("abort_a_out1", a_out1, 0);
        checkOutput("abort_a_out2", a_out2, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_count", count, 0);
        checkOutput("abort_done", done, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("abort_no_done", done, 0);
        end
        applyStimulus(16'h0042, 16'h0043);
        applyStimulus(16'h0044, 16'h0045);
        startAndCheck(1'b0);

`ifdef INPUT_SETUP_REPLAY_EN
        // Replay the same tile twice without rewriting it
        resetDut();
        applyStimulus(16'd7, 16'd8);
        applyStimulus(16'd9, 16'd10);
        startAndCheck(1'b0);
        startAndCheck(1'b0);
        checkOutput("replay_count", count, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
